idli_utx_m: RTL and testbench

IDLI_UTX_M -- requirements
Module: idli_utx_m

---
 rtl/idli_utx_m.sv | 185 ++++++++++++++++++
 tb/tb_idli_utx_m.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_utx_m.sv
// idli_utx_m -- nibble-fed UART transmitter (8N1, LSB first).
//
// Two 4-bit nibbles from the EX stage are assembled into one byte. The low
// nibble arrives first. Each byte is queued in a small circular FIFO, and a
// four-state serialiser shifts it out. A frame is one start bit, eight data
// bits and one stop bit, and each bit lasts BAUD_DIV clocks.
//
// Parameters
//   BAUD_DIV   clocks per serial bit (2..255)
//   FIFO_DEPTH byte entries in the TX FIFO (power of two, >= 2)
//
// Ports
//   i_utx_gck   core gated clock; all state updates on posedge
//   i_utx_rst   asynchronous active-high reset
//   i_utx_data  nibble from EX ALU output (sqi_data_t)
//   i_utx_vld   nibble valid; phase toggles on every valid cycle
//   o_utx_rdy   FIFO has >= 2 free entries (combinational from occupancy)
//   o_utx_tx    serial line, idle high, driven from a flop
//   o_utx_busy  serialiser active or FIFO non-empty
//   o_utx_ovf   sticky overflow: a completed byte was dropped
module idli_utx_m #(
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_utx_gck,
  input  logic       i_utx_rst,
  input  logic [3:0] i_utx_data,
  input  logic       i_utx_vld,
  output logic       o_utx_rdy,
  output logic       o_utx_tx,
  output logic       o_utx_busy,
  output logic       o_utx_ovf
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  BAUD_LAST = 8'(BAUD_DIV - 1);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] RDY_MAX   = (AW+1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  // Nibble assembly
  logic       phase;
  logic [3:0] lo_nib;

  // FIFO. The pointers carry one extra wrap bit so full and empty can be told apart.
  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW:0]                wr_ptr, rd_ptr, count;
  logic                       full, empty, push, push_ok, pop;
  logic [7:0]                 head;

  // Serialiser
  state_t     state, state_nx;
  logic [7:0] baud_cnt, baud_nx;
  logic [2:0] bit_idx, bit_nx;
  logic [7:0] shreg, shreg_nx;
  logic       tx_nx, bit_end;

  assign count      = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign o_utx_rdy  = (count <= RDY_MAX);
  assign o_utx_busy = (state != ST_IDLE) || !empty;

  // A byte completes when the phase-1 nibble is sampled. A same-edge pop
  // frees the slot, so a push into a full FIFO still succeeds in that case.
  assign push    = i_utx_vld && phase;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge i_utx_gck or posedge i_utx_rst) begin
    if (i_utx_rst) begin
      phase  <= 1'b0;
      lo_nib <= '0;
    end else if (i_utx_vld) begin
      phase <= ~phase;
      if (!phase) lo_nib <= i_utx_data;
    end
  end

  always_ff @(posedge i_utx_gck or posedge i_utx_rst) begin
    if (i_utx_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_utx_ovf <= 1'b0;
    end else begin
      if (push_ok)                wr_ptr    <= wr_ptr + PTR_ONE;
      if (pop)                    rd_ptr    <= rd_ptr + PTR_ONE;
      if (push && full && !pop)   o_utx_ovf <= 1'b1;
    end
  end

  // Storage needs no reset. When push and pop hit the same slot while the
  // FIFO is full, the head byte is read into shreg before it is overwritten.
  always_ff @(posedge i_utx_gck) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {i_utx_data, lo_nib};
  end

  assign bit_end = (baud_cnt == '0);

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    tx_nx    = o_utx_tx;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_nx = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          shreg_nx = head;
          baud_nx  = BAUD_LAST;
          state_nx = ST_START;
          tx_nx    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nx = ST_DATA;
          bit_nx   = '0;
          baud_nx  = BAUD_LAST;
          tx_nx    = shreg[0];
        end else begin
          baud_nx = baud_cnt - 8'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_nx = shreg >> 1;
          bit_nx   = bit_idx + 3'd1;
          baud_nx  = BAUD_LAST;
          if (bit_idx == 3'd7) begin
            state_nx = ST_STOP;
            tx_nx    = 1'b1;
          end else begin
            tx_nx = shreg[1];  // the next bit, which shreg[0] holds once the shift lands
          end
        end else begin
          baud_nx = baud_cnt - 8'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            // Chain straight into the next start bit so frames stay contiguous.
            pop      = 1'b1;
            shreg_nx = head;
            baud_nx  = BAUD_LAST;
            state_nx = ST_START;
            tx_nx    = 1'b0;
          end else begin
            state_nx = ST_IDLE;
            tx_nx    = 1'b1;
          end
        end else begin
          baud_nx = baud_cnt - 8'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_utx_gck or posedge i_utx_rst) begin
    if (i_utx_rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      o_utx_tx <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      shreg    <= shreg_nx;
      o_utx_tx <= tx_nx;
    end
  end

endmodule

// File: tb/tb_idli_utx_m.sv
// Testbench for idli_utx_m.
//
// The reference model tracks the FIFO as a byte queue and the serial line as
// the position within a 10*B-cycle frame. Outputs are compared every
// negedge. A line receiver decodes the frames back into bytes. Literal
// expectations pin the start-bit latency, the 0xA5 bit pattern and the busy
// durations.
module tb_idli_utx_m;
  localparam int B = 16;
  localparam int D = 4;

  logic       clk, rst, vld;
  logic [3:0] data;
  logic       rdy, tx, busy, ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int push_edge;
  int busy_cyc = 0;

  idli_utx_m #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
    .i_utx_gck (clk),
    .i_utx_rst (rst),
    .i_utx_data(data),
    .i_utx_vld (vld),
    .o_utx_rdy (rdy),
    .o_utx_tx  (tx),
    .o_utx_busy(busy),
    .o_utx_ovf (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst && busy) busy_cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  logic [3:0] m_lo;
  logic       m_ph, m_act, m_ovf;
  int         m_t;

  task automatic m_reset();
    m_q.delete();
    m_ph = 1'b0; m_act = 1'b0; m_ovf = 1'b0; m_t = 0; m_lo = '0; m_cur = '0;
  endtask

  function automatic logic m_tx_f();
    if (!m_act)     return 1'b1;
    if (m_t < B)    return 1'b0;
    if (m_t < 9*B)  return m_cur[m_t/B - 1];
    return 1'b1;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else begin
        // The pop is decided on the pre-edge queue contents, so a byte pushed on this edge cannot be popped on it.
        if (m_act) begin
          m_t++;
          if (m_t == 10*B) begin
            if (m_q.size() > 0) begin m_cur = m_q.pop_front(); m_t = 0; end
            else m_act = 1'b0;
          end
        end else if (m_q.size() > 0) begin
          m_cur = m_q.pop_front(); m_act = 1'b1; m_t = 0;
        end
        if (vld) begin
          if (m_ph) begin
            if (m_q.size() < D) m_q.push_back({data, m_lo});
            else m_ovf = 1'b1;
          end else m_lo = data;
          m_ph = !m_ph;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("cmp_tx",   tx,   m_tx_f());
      chk("cmp_busy", busy, m_act || (m_q.size() != 0));
      chk("cmp_rdy",  rdy,  (D - m_q.size()) >= 2);
      chk("cmp_ovf",  ovf,  m_ovf);
    end
  end

  // ---------------- line receiver ----------------
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rx_sh;
  int         rx_cnt = 0;

  initial forever begin
    @(negedge clk or posedge rst);
    if (rst) rx_cnt = 0;
    else if (rx_cnt == 0) begin
      if (!tx) begin rx_cnt = 1; rx_sh = '0; end
    end else begin
      rx_cnt++;
      for (int k = 0; k < 8; k++)
        if (rx_cnt == (k+1)*B + B/2) rx_sh[k] = tx;
      if (rx_cnt == 9*B + B/2) begin
        chk("rx_stop", tx, 1);
        rx_q.push_back(rx_sh);
        rx_cnt = 0;
      end
    end
  end

  task automatic chk_rx(input string nm);
    chk({nm, "_count"}, rx_q.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++) chk(nm, rx_q[i], exp_rx[i]);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); vld = 1'b1; data = b[3:0];
    @(negedge clk); data = b[7:4]; push_edge = cyc + 1;
  endtask

  task automatic send_byte_rdy(input logic [7:0] b);
    int g = 0;
    @(negedge clk);
    while (!rdy && g < 2000) begin vld = 1'b0; @(negedge clk); g++; end
    if (g >= 2000) begin checks++; errors++; $display("FAIL rdy_timeout: rdy still %0b", rdy); end
    vld = 1'b1; data = b[3:0];
    @(negedge clk); data = b[7:4]; push_edge = cyc + 1;
  endtask

  task automatic idle_in();
    @(negedge clk); vld = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    @(negedge clk);
    while ((busy || rx_cnt != 0) && n < bound) begin @(negedge clk); n++; end
    if (n >= bound) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy %0b after %0d cycles", busy, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk); rst = 1'b1; vld = 1'b0;
    #1;
    chk({nm, "_rst_tx"},   tx,   1);
    chk({nm, "_rst_busy"}, busy, 0);
    chk({nm, "_rst_rdy"},  rdy,  1);
    chk({nm, "_rst_ovf"},  ovf,  0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    rx_q.delete(); exp_rx.delete(); busy_cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int bits_lit[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int pa;

  initial begin
    rst = 1'b1; vld = 1'b0; data = '0;
    #3;
    chk("reset_tx",   tx,   1);
    chk("reset_busy", busy, 0);
    chk("reset_rdy",  rdy,  1);
    chk("reset_ovf",  ovf,  0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single byte 0xA5 sent as nibbles 0x5 then 0xA
    rx_q.delete(); exp_rx.delete(); busy_cyc = 0;
    send_byte(8'hA5);
    idle_in();
    @(posedge clk); #1;
    chk("a5_start_edge", tx, 0);
    for (int i = 1; i <= 170; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++)
        if (i == (k+1)*B + B/2) chk("a5_bit", tx, bits_lit[k]);
      if (i == 9*B + B/2) chk("a5_stop", tx, 1);
      if (i == 159) chk("a5_busy_hi", busy, 1);
      if (i == 160) chk("a5_busy_lo", busy, 0);
    end
    exp_rx.push_back(8'hA5);
    wait_idle(400);
    chk_rx("a5_rx");
    chk("a5_busy_len", busy_cyc, 161);

    // Back-to-back 0x00, 0xFF: 320 contiguous frame cycles
    do_reset("b2b");
    send_byte(8'h00);
    send_byte(8'hFF);
    idle_in();
    exp_rx.push_back(8'h00); exp_rx.push_back(8'hFF);
    wait_idle(800);
    chk_rx("b2b_rx");
    chk("b2b_busy_len", busy_cyc, 321);

    // Overflow: six bytes while the first is on the line, the sixth is dropped
    do_reset("ovf");
    for (int b = 1; b <= 6; b++) send_byte(8'(b * 17));
    idle_in();
    chk("ovf_set", ovf, 1);
    for (int b = 1; b <= 5; b++) exp_rx.push_back(8'(b * 17));
    wait_idle(1500);
    chk_rx("ovf_rx");
    chk("ovf_sticky", ovf, 1);

    // Push on the STOP-end edge with the FIFO full
    do_reset("pp");
    send_byte(8'h81);
    pa = push_edge;
    for (int b = 2; b <= 5; b++) send_byte(8'(8'h80 + b));
    idle_in();
    chk("pp_full_rdy", rdy, 0);
    while (cyc < pa + 158) @(negedge clk);
    send_byte(8'h86);  // high nibble sampled at edge pa+161, when the first frame ends
    idle_in();
    chk("pp_ovf_clear", ovf, 0);
    for (int b = 1; b <= 6; b++) exp_rx.push_back(8'(8'h80 + b));
    wait_idle(1500);
    chk_rx("pp_rx");

    // Reset during data bit 3 of 0xC3 (a 0 bit), with a dangling nibble pending
    do_reset("mid");
    send_byte(8'hC3);
    pa = push_edge;
    @(negedge clk); data = 4'hF;
    idle_in();
    while (cyc < pa + 72) @(negedge clk);
    #2;
    chk("mid_bit3_low", tx, 0);
    rst = 1'b1;
    #1;
    chk("mid_async_tx",   tx,   1);
    chk("mid_async_busy", busy, 0);
    chk("mid_async_rdy",  rdy,  1);
    chk("mid_async_ovf",  ovf,  0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    rx_q.delete(); exp_rx.delete();
    send_byte(8'h21);
    idle_in();
    exp_rx.push_back(8'h21);
    wait_idle(400);
    chk_rx("mid_rx");

    // Pointer wrap: 20 bytes paced by rdy
    do_reset("wrap");
    for (int b = 0; b < 20; b++) send_byte_rdy(8'(b));
    idle_in();
    for (int b = 0; b < 20; b++) exp_rx.push_back(8'(b));
    wait_idle(5000);
    chk_rx("wrap_rx");
    chk("wrap_no_ovf", ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
